// File: rtl/poly_eval_sched.sv
// Purpose: pops coefficient pairs, issues them to the fixed-latency combine unit, merges results and coefficients onto the pair-queue write port.
// Latency: que handshake t -> op_vld t+1 -> res_vld t+1+LAT -> wr_vld t+2+LAT; coef handshake t -> wr_vld t+1.
// Backpressure: que_rdy drops at MAX_INFL in flight; coef_rdy drops whenever a result owns the write port; the combine unit never stalls.
//
// Ports: clk, rst_n (sync, active-low); start/busy/done/err run control; coef_* input stream;
//        que_* pair-queue pop side; op_* issue to combine unit; res_* combine-unit return;
//        wr_* pair-queue write port; stat_issue/stat_cstall statistics.
// Optional feature macro: POLY_SCHED_STAT_EN (statistics counters; ports tie to 0 when undefined).
module poly_eval_sched #(
    parameter int WID_D     = 32,
    parameter int CNT_W     = 5,
    parameter int LAT       = 4,
    parameter int MAX_INFL  = 8,
    parameter int NUM_COEF  = 32,
    parameter int FINAL_CNT = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             coef_vld,
    input  logic [WID_D-1:0] coef_data,
    output logic             coef_rdy,
    input  logic             que_vld,
    input  logic [WID_D-1:0] que_left,
    input  logic [WID_D-1:0] que_right,
    input  logic [CNT_W-1:0] que_cnt,
    output logic             que_rdy,
    output logic             op_vld,
    output logic [WID_D-1:0] op_left,
    output logic [WID_D-1:0] op_right,
    input  logic             res_vld,
    input  logic [WID_D-1:0] res_data,
    output logic             wr_vld,
    output logic [WID_D-1:0] wr_data,
    output logic [CNT_W-1:0] wr_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [15:0]      stat_issue,
    output logic [15:0]      stat_cstall
);

    localparam int IW = $clog2(MAX_INFL + 1);
    localparam int CW = $clog2(NUM_COEF + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    coef_cnt;
    logic             final_flg;
    logic [IW-1:0]    infl;

    // Shadow pipeline: stage 0 runs alongside the issue register, stage LAT
    // lines up with the cycle the combine unit must present its result.
    logic [LAT:0]     sh_vld;
    logic [CNT_W-1:0] sh_cnt [LAT+1];

    logic             tail_vld;
    logic [CNT_W-1:0] tail_cnt;
    logic             coef_hs;
    logic             que_hs;
    logic             res_wr;
    logic             start_run;
    logic             wr_load;
    logic [WID_D-1:0] wr_data_nxt;
    logic [CNT_W-1:0] wr_cnt_nxt;

    assign tail_vld  = sh_vld[LAT];
    assign tail_cnt  = sh_cnt[LAT];
    assign start_run = (state == S_IDLE) && start;

    // A result owns the write port in its tail cycle, so the coefficient waits.
    assign coef_rdy = (state == S_RUN) && !tail_vld;
    // The tail pop frees a slot in the same cycle, keeping issue back-to-back at the cap.
    assign que_rdy  = ((state == S_RUN) || (state == S_DRAIN)) &&
                      ((infl < IW'(MAX_INFL)) || tail_vld);

    assign coef_hs = coef_vld && coef_rdy;
    assign que_hs  = que_vld && que_rdy;
    assign res_wr  = res_vld && tail_vld;

    always_comb begin
        wr_load     = 1'b0;
        wr_data_nxt = coef_data;
        wr_cnt_nxt  = '0;
        if (res_wr) begin
            wr_load     = 1'b1;
            wr_data_nxt = res_data;
            wr_cnt_nxt  = tail_cnt;
        end else if (coef_hs) begin
            wr_load = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (coef_hs && (coef_cnt == CW'(NUM_COEF - 1))) state_nxt = S_DRAIN;
            S_DRAIN: if ((infl == '0) && final_flg) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            coef_cnt  <= '0;
            final_flg <= 1'b0;
            infl      <= '0;
            sh_vld    <= '0;
            for (int i = 0; i <= LAT; i++) sh_cnt[i] <= '0;
            op_vld    <= 1'b0;
            op_left   <= '0;
            op_right  <= '0;
            wr_vld    <= 1'b0;
            wr_data   <= '0;
            wr_cnt    <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;

            if (start_run)    coef_cnt <= '0;
            else if (coef_hs) coef_cnt <= coef_cnt + CW'(1);

            if (start_run)
                final_flg <= 1'b0;
            else if (wr_load && (wr_cnt_nxt == CNT_W'(FINAL_CNT)))
                final_flg <= 1'b1;

            case ({que_hs, tail_vld})
                2'b10:   infl <= infl + IW'(1);
                2'b01:   infl <= infl - IW'(1);
                default: infl <= infl;
            endcase

            // Order count wraps modulo 2^CNT_W by design.
            sh_vld    <= {sh_vld[LAT-1:0], que_hs};
            sh_cnt[0] <= que_hs ? (que_cnt + CNT_W'(1)) : '0;
            for (int i = 1; i <= LAT; i++) sh_cnt[i] <= sh_cnt[i-1];

            op_vld <= que_hs;
            if (que_hs) begin
                op_left  <= que_left;
                op_right <= que_right;
            end

            wr_vld <= wr_load;
            if (wr_load) begin
                wr_data <= wr_data_nxt;
                wr_cnt  <= wr_cnt_nxt;
            end

            // Return without a matching shadow slot (or a missing return) is fatal
            // to the run; the stray result is simply not written.
            if (res_vld != tail_vld) err <= 1'b1;
        end
    end

`ifdef POLY_SCHED_STAT_EN
    logic [15:0] issue_q;
    logic [15:0] cstall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_q  <= '0;
            cstall_q <= '0;
        end else if (start_run) begin
            issue_q  <= '0;
            cstall_q <= '0;
        end else begin
            if (que_hs && (issue_q != 16'hFFFF)) issue_q <= issue_q + 16'd1;
            if (coef_vld && !coef_rdy && (cstall_q != 16'hFFFF)) cstall_q <= cstall_q + 16'd1;
        end
    end

    assign stat_issue  = issue_q;
    assign stat_cstall = cstall_q;
`else
    assign stat_issue  = '0;
    assign stat_cstall = '0;
`endif

endmodule

// File: tb/tb_poly_eval_sched.sv
// Purpose: randomized and directed stimulus for poly_eval_sched, checked every cycle against a transaction-level model.
// Latency: model tracks ops by their expected return cycle and writes by their expected write cycle.
// Backpressure: coefficient source holds data until accepted; combine-unit model returns each op on its due cycle.
module tb_poly_eval_sched;

    localparam int WID_D     = 32;
    localparam int CNT_W     = 5;
    localparam int LAT       = 4;
    localparam int MAX_INFL  = 4;
    localparam int NUM_COEF  = 32;
    localparam int FINAL_CNT = 5;
`ifdef POLY_SCHED_STAT_EN
    localparam int STAT_ON = 1;
`else
    localparam int STAT_ON = 0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             coef_vld;
    logic [WID_D-1:0] coef_data;
    logic             coef_rdy;
    logic             que_vld;
    logic [WID_D-1:0] que_left;
    logic [WID_D-1:0] que_right;
    logic [CNT_W-1:0] que_cnt;
    logic             que_rdy;
    logic             op_vld;
    logic [WID_D-1:0] op_left;
    logic [WID_D-1:0] op_right;
    logic             res_vld;
    logic [WID_D-1:0] res_data;
    logic             wr_vld;
    logic [WID_D-1:0] wr_data;
    logic [CNT_W-1:0] wr_cnt;
    logic             busy;
    logic             done;
    logic             err;
    logic [15:0]      stat_issue;
    logic [15:0]      stat_cstall;

    poly_eval_sched #(
        .WID_D(WID_D), .CNT_W(CNT_W), .LAT(LAT), .MAX_INFL(MAX_INFL),
        .NUM_COEF(NUM_COEF), .FINAL_CNT(FINAL_CNT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .coef_vld(coef_vld), .coef_data(coef_data), .coef_rdy(coef_rdy),
        .que_vld(que_vld), .que_left(que_left), .que_right(que_right),
        .que_cnt(que_cnt), .que_rdy(que_rdy),
        .op_vld(op_vld), .op_left(op_left), .op_right(op_right),
        .res_vld(res_vld), .res_data(res_data),
        .wr_vld(wr_vld), .wr_data(wr_data), .wr_cnt(wr_cnt),
        .busy(busy), .done(done), .err(err),
        .stat_issue(stat_issue), .stat_cstall(stat_cstall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int               ret;   // cycle the combine unit must return this op
        logic [CNT_W-1:0] cnt;
        logic [WID_D-1:0] dat;
    } op_t;
    typedef struct {
        int               cyc;   // cycle wr_vld must be visible
        logic [WID_D-1:0] d;
        logic [CNT_W-1:0] c;
    } wr_t;

    op_t              m_ops[$];
    wr_t              m_wrs[$];
    int               n;
    int               ph;        // 0 idle, 1 run, 2 drain, 3 done
    int               m_coefs;
    bit               m_final;
    bit               m_err;
    int               m_iss;
    int               m_cst;
    bit               m_opv;
    logic [WID_D-1:0] m_opl;
    logic [WID_D-1:0] m_opr;
    bit               last_coef_hs;
    bit               last_que_hs;
    bit               spur;
    int               checks;
    int               errors;

    function automatic logic [WID_D-1:0] combine(input logic [WID_D-1:0] l, input logic [WID_D-1:0] r);
        return l + r + 32'd5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, n);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, n);
    endtask

    task automatic m_reset();
        m_ops.delete();
        m_wrs.delete();
        ph = 0; m_coefs = 0; m_final = 0; m_err = 0;
        m_iss = 0; m_cst = 0; m_opv = 0; m_opl = '0; m_opr = '0;
        last_coef_hs = 0; last_que_hs = 0;
    endtask

    // One clock cycle: combine-unit response, compare, model update, advance.
    task automatic step();
        bit               tail;
        logic [CNT_W-1:0] tcnt;
        logic [WID_D-1:0] tdat;
        bit               e_qrdy, e_crdy, e_wr, q_hs, c_hs, drain_go, fset;
        int               outstanding;
        tail = 0; tcnt = '0; tdat = '0;
        if (m_ops.size() > 0 && m_ops[0].ret == n) begin
            tail = 1; tcnt = m_ops[0].cnt; tdat = m_ops[0].dat;
        end
        res_vld  = tail || spur;
        res_data = tail ? tdat : '0;
        #1;
        outstanding = m_ops.size() - int'(tail);
        e_qrdy = (ph == 1 || ph == 2) && (outstanding < MAX_INFL);
        e_crdy = (ph == 1) && !tail;
        e_wr   = (m_wrs.size() > 0) && (m_wrs[0].cyc == n);

        chk("que_rdy", que_rdy, e_qrdy);
        chk("coef_rdy", coef_rdy, e_crdy);
        chk("busy", busy, ph != 0);
        chk("done", done, ph == 3);
        chk("err", err, m_err);
        chk("op_vld", op_vld, m_opv);
        if (m_opv) begin
            chk("op_left", op_left, m_opl);
            chk("op_right", op_right, m_opr);
        end
        chk("wr_vld", wr_vld, e_wr);
        if (e_wr) begin
            chk("wr_data", wr_data, m_wrs[0].d);
            chk("wr_cnt", wr_cnt, m_wrs[0].c);
            void'(m_wrs.pop_front());
        end
        chk("stat_issue", stat_issue, STAT_ON ? m_iss : 0);
        chk("stat_cstall", stat_cstall, STAT_ON ? m_cst : 0);

        if (!rst_n) begin
            m_reset();
        end else begin
            q_hs     = que_vld && e_qrdy;
            c_hs     = coef_vld && e_crdy;
            drain_go = (ph == 2) && (m_ops.size() == 0) && m_final;
            if (res_vld != tail) m_err = 1;
            fset = 0;
            if (res_vld && tail) begin
                m_wrs.push_back('{cyc: n + 1, d: res_data, c: tcnt});
                fset = (tcnt == CNT_W'(FINAL_CNT));
            end else if (c_hs) begin
                m_wrs.push_back('{cyc: n + 1, d: coef_data, c: '0});
                fset = (FINAL_CNT == 0);
            end
            if (tail) void'(m_ops.pop_front());
            if (q_hs) begin
                logic [CNT_W-1:0] c1;
                c1 = que_cnt + CNT_W'(1);
                m_ops.push_back('{ret: n + 1 + LAT, cnt: c1, dat: combine(que_left, que_right)});
            end
            m_opv = q_hs; m_opl = que_left; m_opr = que_right;
            if (ph == 0 && start) begin
                m_iss = 0; m_cst = 0; m_final = 0; m_coefs = 0; ph = 1;
            end else begin
                if (q_hs && m_iss < 16'hFFFF) m_iss++;
                if (coef_vld && !e_crdy && m_cst < 16'hFFFF) m_cst++;
                if (fset) m_final = 1;
                case (ph)
                    1: if (c_hs) begin
                           m_coefs++;
                           if (m_coefs == NUM_COEF) ph = 2;
                       end
                    2: if (drain_go) ph = 3;
                    3: ph = 0;
                    default: ;
                endcase
            end
            last_coef_hs = c_hs;
            last_que_hs  = q_hs;
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_rand();
        if (ph == 1) begin
            if (!(coef_vld && !last_coef_hs)) begin
                coef_vld  = ($urandom_range(0, 9) < 6);
                coef_data = $urandom;
            end
        end else begin
            coef_vld = 0;
        end
        que_vld   = $urandom_range(0, 1);
        que_left  = $urandom;
        que_right = $urandom;
        case ($urandom_range(0, 4))
            0: que_cnt = 5'd0;
            1: que_cnt = 5'd1;
            2: que_cnt = 5'd2;
            3: que_cnt = 5'd3;
            default: que_cnt = 5'd31;   // exercises the modulo wrap
        endcase
    endtask

    task automatic run_to_drain();
        int g;
        start = 1; step(); start = 0;
        g = 0;
        while (ph != 2 && g < 500) begin
            drive_rand(); step(); g++;
        end
        coef_vld = 0; que_vld = 0;
        if (ph != 2) fail("reach_drain");
    endtask

    task automatic finish_run();
        int g, dcnt;
        que_cnt = CNT_W'(FINAL_CNT - 1); que_left = $urandom; que_right = $urandom;
        que_vld = 1; g = 0;
        do begin step(); g++; end while (!last_que_hs && g < 20);
        que_vld = 0;
        if (!last_que_hs) fail("final_issue");
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dcnt++;
            step();
        end
        chk("done_pulses", dcnt, 1);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int h, g, m0, dcnt;
        checks = 0; errors = 0; n = 0; spur = 0;
        m_reset();
        rst_n = 0; start = 0; coef_vld = 0; coef_data = '0;
        que_vld = 0; que_left = '0; que_right = '0; que_cnt = '0;
        res_vld = 0; res_data = '0;
        @(posedge clk); #1;
        repeat (2) step();

        // reset values
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_op_left", op_left, 0);
        chk("rst_que_rdy", que_rdy, 0);
        rst_n = 1; step();

        // Run A: 32 coefficients 1000.., one pair (2,5,7) returning 0x11, stall on return
        start = 1; step(); start = 0;
        h = n; g = 0;
        while (m_coefs < NUM_COEF && g < 200) begin
            coef_vld = 1; coef_data = 1000 + m_coefs;
            que_vld = (n == h); que_cnt = 5'd2; que_left = 5; que_right = 7;
            if (n == h + 5) chk("stall_coef_rdy", coef_rdy, 0);
            if (n == h + 6) begin
                chk("res_wr_vld", wr_vld, 1);
                chk("res_wr_data", wr_data, 32'h11);
                chk("res_wr_cnt", wr_cnt, 3);
            end
            if (n == h + 7) chk("held_coef_data", wr_data, 1005);
            step(); g++;
        end
        coef_vld = 0; que_vld = 0;
        chk("last_coef_data", wr_data, 1031);
        chk("drain_coef_rdy", coef_rdy, 0);
        chk("drain_que_rdy", que_rdy, 1);
        chk("cstall_once", stat_cstall, STAT_ON ? 1 : 0);
        chk("issue_once", stat_issue, STAT_ON ? 1 : 0);

        // in-flight cap: MAX_INFL issues, one blocked cycle, reopen on first pop
        m0 = n; que_vld = 1; que_cnt = 5'd0;
        for (int k = 0; k <= MAX_INFL + 1; k++) begin
            que_left = $urandom; que_right = $urandom;
            chk("cap_que_rdy", que_rdy, (k != MAX_INFL));
            step();
        end
        que_vld = 0;
        finish_run();

        // spurious return: sticky err, nothing written, cleared only by reset
        spur = 1; step(); spur = 0;
        chk("spur_err", err, 1);
        chk("spur_no_wr", wr_vld, 0);
        start = 1; step(); start = 0;
        repeat (3) step();
        chk("err_sticky", err, 1);
        rst_n = 0; step(); rst_n = 1;
        chk("err_cleared", err, 0);
        step();

        // Run B: random run, then reset mid-DRAIN with ops in flight
        run_to_drain();
        que_vld = 1; que_cnt = 5'd1; que_left = $urandom; que_right = $urandom;
        repeat (2) step();
        que_vld = 0; rst_n = 0; step(); rst_n = 1;
        chk("abort_busy", busy, 0);
        chk("abort_op_vld", op_vld, 0);
        chk("abort_wr_vld", wr_vld, 0);
        chk("abort_wr_data", wr_data, 0);
        chk("abort_op_left", op_left, 0);
        chk("abort_stat", stat_issue, 0);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) dcnt++;
            step();
        end
        chk("abort_no_done", dcnt, 0);

        // Run C: random full run ending in done
        run_to_drain();
        finish_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
